// File: rtl/mem_lsu_pkg.sv
// Shared opcodes, FSM encoding and bus payload type for the MEM-stage load/store unit.
package mem_lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned SEL_W  = 4;

    // Load/store aluOp codes as emitted by the decode stage
    localparam logic [OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] wdata;
    } dbus_req_t;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte selects, store replication, load extraction/extension
// and alignment check for big-endian MIPS32 memory accesses.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [OP_W-1:0]   alu_op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] load_word,
    output logic              is_load_c,
    output logic              is_store_c,
    output logic              misaligned_c,
    output logic [SEL_W-1:0]  sel_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] load_data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Big-endian lane pick: address 0 is the most significant byte
    always_comb begin
        byte_v = 8'h00;
        case (addr_lo)
            2'b00:   byte_v = load_word[31:24];
            2'b01:   byte_v = load_word[23:16];
            2'b10:   byte_v = load_word[15:8];
            default: byte_v = load_word[7:0];
        endcase
        half_v = addr_lo[1] ? load_word[15:0] : load_word[31:16];
    end

    always_comb begin
        is_load_c    = 1'b0;
        is_store_c   = 1'b0;
        misaligned_c = 1'b0;
        sel_c        = '0;
        wdata_c      = '0;
        load_data_c  = '0;
        case (alu_op)
            EXE_LB_OP: begin
                is_load_c   = 1'b1;
                sel_c       = 4'b1000 >> addr_lo;
                load_data_c = {{24{byte_v[7]}}, byte_v};
            end
            EXE_LBU_OP: begin
                is_load_c   = 1'b1;
                sel_c       = 4'b1000 >> addr_lo;
                load_data_c = {24'h000000, byte_v};
            end
            EXE_LH_OP: begin
                is_load_c    = 1'b1;
                misaligned_c = addr_lo[0];
                sel_c        = addr_lo[1] ? 4'b0011 : 4'b1100;
                load_data_c  = {{16{half_v[15]}}, half_v};
            end
            EXE_LHU_OP: begin
                is_load_c    = 1'b1;
                misaligned_c = addr_lo[0];
                sel_c        = addr_lo[1] ? 4'b0011 : 4'b1100;
                load_data_c  = {16'h0000, half_v};
            end
            EXE_LW_OP: begin
                is_load_c    = 1'b1;
                misaligned_c = |addr_lo;
                sel_c        = 4'b1111;
                load_data_c  = load_word;
            end
            EXE_SB_OP: begin
                is_store_c = 1'b1;
                sel_c      = 4'b1000 >> addr_lo;
                wdata_c    = {4{store_data[7:0]}};
            end
            EXE_SH_OP: begin
                is_store_c   = 1'b1;
                misaligned_c = addr_lo[0];
                sel_c        = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata_c      = {2{store_data[15:0]}};
            end
            EXE_SW_OP: begin
                is_store_c   = 1'b1;
                misaligned_c = |addr_lo;
                sel_c        = 4'b1111;
                wdata_c      = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives a req/ack data bus with wait states, stalls the
// pipeline while an access is outstanding, and forwards the write-back bundle.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wReg,
    input  logic [4:0]  mem_wAddr,
    input  logic [31:0] mem_wData,
    input  logic        mem_wHiLo,
    input  logic [31:0] mem_hiData,
    input  logic [31:0] mem_loData,
    input  logic [7:0]  mem_aluOp,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_opNum2,
    output logic        wb_wReg,
    output logic [4:0]  wb_wAddr,
    output logic [31:0] wb_wData,
    output logic        wb_wHiLo,
    output logic [31:0] wb_hiData,
    output logic [31:0] wb_loData,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        stallreq,
    output logic        adel,
    output logic        ades,
    output logic        bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              is_load_c;
    logic              is_store_c;
    logic              misaligned_c;
    logic [SEL_W-1:0]  sel_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] load_data_c;
    logic              go_c;
    logic              timeout_hit_c;
    logic              req_c;
    dbus_req_t         bus_c;

    mem_lsu_align u_align (
        .alu_op       (mem_aluOp),
        .addr_lo      (mem_mem_addr[1:0]),
        .store_data   (mem_opNum2),
        .load_word    (rdata_q),
        .is_load_c    (is_load_c),
        .is_store_c   (is_store_c),
        .misaligned_c (misaligned_c),
        .sel_c        (sel_c),
        .wdata_c      (wdata_c),
        .load_data_c  (load_data_c)
    );

    assign go_c          = (is_load_c | is_store_c) & ~misaligned_c;
    assign timeout_hit_c = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        bus_c.we    = is_store_c;
        bus_c.addr  = {mem_mem_addr[31:2], 2'b00};
        bus_c.sel   = sel_c;
        bus_c.wdata = wdata_c;
    end

    // An ack already present in the request cycle completes the access without waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LSU_IDLE;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (go_c) begin
                        wait_cnt <= '0;
                        err_q    <= 1'b0;
                        if (dbus_ack) begin
                            rdata_q <= dbus_rdata;
                            state   <= LSU_DONE;
                        end else begin
                            state <= LSU_ACCESS;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (dbus_ack) begin
                        rdata_q <= dbus_rdata;
                        state   <= LSU_DONE;
                    end else if (timeout_hit_c) begin
                        err_q <= 1'b1;
                        state <= LSU_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                LSU_DONE: begin
                    err_q <= 1'b0;
                    state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

    // Outputs are forced low during reset so an in-flight request is abandoned at once
    always_comb begin
        req_c      = 1'b0;
        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = '0;
        dbus_sel   = '0;
        dbus_wdata = '0;
        stallreq   = 1'b0;
        adel       = 1'b0;
        ades       = 1'b0;
        bus_err    = 1'b0;
        wb_wReg    = 1'b0;
        wb_wAddr   = '0;
        wb_wData   = '0;
        wb_wHiLo   = 1'b0;
        wb_hiData  = '0;
        wb_loData  = '0;
        if (!rst) begin
            wb_wHiLo  = mem_wHiLo;
            wb_hiData = mem_hiData;
            wb_loData = mem_loData;
            wb_wAddr  = mem_wAddr;
            wb_wData  = mem_wData;
            case (state)
                LSU_IDLE: begin
                    if (go_c) begin
                        req_c    = 1'b1;
                        stallreq = 1'b1;
                    end else begin
                        wb_wReg = mem_wReg & ~misaligned_c;
                        adel    = is_load_c & misaligned_c;
                        ades    = is_store_c & misaligned_c;
                    end
                end
                LSU_ACCESS: begin
                    req_c    = 1'b1;
                    stallreq = 1'b1;
                end
                LSU_DONE: begin
                    wb_wReg = mem_wReg & ~err_q;
                    bus_err = err_q;
                    if (is_load_c) begin
                        wb_wData = load_data_c;
                    end
                end
                default: ;
            endcase
            if (req_c) begin
                dbus_req   = 1'b1;
                dbus_we    = bus_c.we;
                dbus_addr  = bus_c.addr;
                dbus_sel   = bus_c.sel;
                dbus_wdata = bus_c.wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: scoreboard of expected MEM-stage results per instruction.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam logic [7:0] OP_ADDU = 8'b0010_0001;

    logic        clk;
    logic        rst;
    logic        mem_wReg;
    logic [4:0]  mem_wAddr;
    logic [31:0] mem_wData;
    logic        mem_wHiLo;
    logic [31:0] mem_hiData;
    logic [31:0] mem_loData;
    logic [7:0]  mem_aluOp;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_opNum2;
    logic        wb_wReg;
    logic [4:0]  wb_wAddr;
    logic [31:0] wb_wData;
    logic        wb_wHiLo;
    logic [31:0] wb_hiData;
    logic [31:0] wb_loData;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        stallreq;
    logic        adel;
    logic        ades;
    logic        bus_err;

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_wReg     (mem_wReg),
        .mem_wAddr    (mem_wAddr),
        .mem_wData    (mem_wData),
        .mem_wHiLo    (mem_wHiLo),
        .mem_hiData   (mem_hiData),
        .mem_loData   (mem_loData),
        .mem_aluOp    (mem_aluOp),
        .mem_mem_addr (mem_mem_addr),
        .mem_opNum2   (mem_opNum2),
        .wb_wReg      (wb_wReg),
        .wb_wAddr     (wb_wAddr),
        .wb_wData     (wb_wData),
        .wb_wHiLo     (wb_wHiLo),
        .wb_hiData    (wb_hiData),
        .wb_loData    (wb_loData),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_sel     (dbus_sel),
        .dbus_wdata   (dbus_wdata),
        .dbus_rdata   (dbus_rdata),
        .dbus_ack     (dbus_ack),
        .stallreq     (stallreq),
        .adel         (adel),
        .ades         (ades),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        chk_wdata;
        int          stalls;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        adel;
        logic        ades;
        logic        berr;
        logic        hilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_ops  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, answer the bus, and compare against the scoreboard head
    task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic wreg, input logic [31:0] wdata_in,
                          input int waits, input logic ack_en, input logic [31:0] rdata,
                          input logic x_wreg, input logic [31:0] x_wdata, input logic x_chkw,
                          input int x_stalls, input logic [3:0] x_sel, input logic x_we,
                          input logic [31:0] x_bwdata, input logic x_adel, input logic x_ades,
                          input logic x_berr);
        exp_t e;
        exp_t h;
        int   stall_cnt = 0;
        logic seen_bus  = 1'b0;
        logic done      = 1'b0;
        n_ops++;
        mem_aluOp    = op;
        mem_mem_addr = addr;
        mem_opNum2   = rt;
        mem_wReg     = wreg;
        mem_wAddr    = 5'(n_ops);
        mem_wData    = wdata_in;
        mem_wHiLo    = n_ops[0];
        mem_hiData   = 32'h1000_0000 + 32'(n_ops);
        mem_loData   = 32'h2000_0000 + 32'(n_ops);
        e = '{wreg: x_wreg, waddr: 5'(n_ops), wdata: x_wdata, chk_wdata: x_chkw,
              stalls: x_stalls, sel: x_sel, we: x_we, baddr: addr & 32'hFFFF_FFFC,
              bwdata: x_bwdata, adel: x_adel, ades: x_ades, berr: x_berr,
              hilo: n_ops[0], hi: 32'h1000_0000 + 32'(n_ops), lo: 32'h2000_0000 + 32'(n_ops)};
        sb_q.push_back(e);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (stallreq) begin
                stall_cnt++;
                if (!seen_bus) begin
                    seen_bus = 1'b1;
                    h = sb_q[0];
                    chk({name, " dbus_req"},  32'(dbus_req), 1);
                    chk({name, " dbus_sel"},  32'(dbus_sel), 32'(h.sel));
                    chk({name, " dbus_we"},   32'(dbus_we),  32'(h.we));
                    chk({name, " dbus_addr"}, dbus_addr, h.baddr);
                    if (h.we) chk({name, " dbus_wdata"}, dbus_wdata, h.bwdata);
                end
                if (ack_en && stall_cnt == waits + 1) begin
                    dbus_ack   = 1'b1;
                    dbus_rdata = rdata;
                end
                @(posedge clk);
                #1;
                dbus_ack   = 1'b0;
                dbus_rdata = 32'h0;
            end else begin
                h = sb_q.pop_front();
                done = 1'b1;
                chk({name, " stall_cycles"}, 32'(stall_cnt), 32'(h.stalls));
                chk({name, " done_req"},     32'(dbus_req), 0);
                chk({name, " wb_wReg"},      32'(wb_wReg),  32'(h.wreg));
                chk({name, " wb_wAddr"},     32'(wb_wAddr), 32'(h.waddr));
                if (h.chk_wdata) chk({name, " wb_wData"}, wb_wData, h.wdata);
                chk({name, " adel"},    32'(adel),    32'(h.adel));
                chk({name, " ades"},    32'(ades),    32'(h.ades));
                chk({name, " bus_err"}, 32'(bus_err), 32'(h.berr));
                chk({name, " wb_wHiLo"},  32'(wb_wHiLo), 32'(h.hilo));
                chk({name, " wb_hiData"}, wb_hiData, h.hi);
                chk({name, " wb_loData"}, wb_loData, h.lo);
                @(posedge clk);
                #1;
            end
        end
        chk({name, " completed"}, 32'(done), 1);
        if (!done && sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    initial begin
        rst          = 1'b1;
        dbus_ack     = 1'b0;
        dbus_rdata   = 32'h0;
        mem_aluOp    = EXE_LW_OP;
        mem_mem_addr = 32'h0000_0100;
        mem_opNum2   = 32'h0;
        mem_wReg     = 1'b1;
        mem_wAddr    = 5'd9;
        mem_wData    = 32'h1234_5678;
        mem_wHiLo    = 1'b1;
        mem_hiData   = 32'hAAAA_5555;
        mem_loData   = 32'h5555_AAAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset dbus_req",  32'(dbus_req), 0);
        chk("reset stallreq",  32'(stallreq), 0);
        chk("reset wb_wReg",   32'(wb_wReg),  0);
        chk("reset wb_wData",  wb_wData, 0);
        chk("reset wb_hiData", wb_hiData, 0);
        chk("reset dbus_sel",  32'(dbus_sel), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //     name    op          addr           rt             wr    wdata  waits ack  rdata          xwr   xwdata         chk  st  sel      we    bwdata         adel  ades  berr
        run_op("LW0",  EXE_LW_OP,  32'h0000_0100, 32'h0,         1'b1, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1, 4'b1111, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0);
        run_op("LB3",  EXE_LB_OP,  32'h0000_0103, 32'h0,         1'b1, 32'h0, 3, 1'b1, 32'h1122_33F0, 1'b1, 32'hFFFF_FFF0, 1'b1, 4, 4'b0001, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0);
        run_op("LBU3", EXE_LBU_OP, 32'h0000_0103, 32'h0,         1'b1, 32'h0, 3, 1'b1, 32'h1122_33F0, 1'b1, 32'h0000_00F0, 1'b1, 4, 4'b0001, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0);
        run_op("LB1",  EXE_LB_OP,  32'h0000_0101, 32'h0,         1'b1, 32'h0, 1, 1'b1, 32'h117F_3344, 1'b1, 32'h0000_007F, 1'b1, 2, 4'b0100, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0);
        run_op("LH2",  EXE_LH_OP,  32'h0000_0102, 32'h0,         1'b1, 32'h0, 2, 1'b1, 32'h1122_8001, 1'b1, 32'hFFFF_8001, 1'b1, 3, 4'b0011, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0);
        run_op("LHU0", EXE_LHU_OP, 32'h0000_0100, 32'h0,         1'b1, 32'h0, 0, 1'b1, 32'h8001_1234, 1'b1, 32'h0000_8001, 1'b1, 1, 4'b1100, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0);
        run_op("SH",   EXE_SH_OP,  32'h0000_0102, 32'h0000_ABCD, 1'b0, 32'h0, 1, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 2, 4'b0011, 1'b1, 32'hABCD_ABCD, 1'b0, 1'b0, 1'b0);
        run_op("SB",   EXE_SB_OP,  32'h0000_0101, 32'h1234_5678, 1'b0, 32'h0, 0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 1, 4'b0100, 1'b1, 32'h7878_7878, 1'b0, 1'b0, 1'b0);
        run_op("SW",   EXE_SW_OP,  32'h0000_0104, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 3, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        run_op("LWmis",EXE_LW_OP,  32'h0000_0101, 32'h0,         1'b1, 32'h0, 0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 0, 4'b0000, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0);
        run_op("SWmis",EXE_SW_OP,  32'h0000_0102, 32'h1111_2222, 1'b0, 32'h0, 0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 0, 4'b0000, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0);
        run_op("LHmis",EXE_LH_OP,  32'h0000_0103, 32'h0,         1'b1, 32'h0, 0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 0, 4'b0000, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0);
        run_op("LWto", EXE_LW_OP,  32'h0000_0200, 32'h0,         1'b1, 32'h0, 0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 5, 4'b1111, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1);
        run_op("ADDU", OP_ADDU,    32'h0000_0000, 32'h0,         1'b1, 32'h55,0, 1'b1, 32'h0,         1'b1, 32'h0000_0055, 1'b1, 0, 4'b0000, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0);
        run_op("LWpost",EXE_LW_OP, 32'h0000_0300, 32'h0,         1'b1, 32'h0, 1, 1'b1, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1, 2, 4'b1111, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0);

        // Reset landing in the second ACCESS cycle of an outstanding load
        mem_aluOp    = EXE_LW_OP;
        mem_mem_addr = 32'h0000_0400;
        mem_wReg     = 1'b1;
        mem_hiData   = 32'h3333_4444;
        @(negedge clk);
        chk("rstmid req_cycle", 32'(stallreq), 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid dbus_req",  32'(dbus_req), 0);
        chk("rstmid stallreq",  32'(stallreq), 0);
        chk("rstmid wb_hiData", wb_hiData, 0);
        mem_aluOp = OP_ADDU;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op("ADDUrst", OP_ADDU, 32'h0, 32'h0, 1'b1, 32'h0000_0077, 0, 1'b1, 32'h0, 1'b1, 32'h0000_0077, 1'b1, 0, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
